// File: rtl/hdlc_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_host_ctrl_if
// Brief    : Client streams plus Hdlc register bus seen by hdlc_host_ctrl.
// Revision : 1.0
// ============================================================================
interface hdlc_host_ctrl_if;
  logic       tx_req;
  logic [7:0] tx_len;
  logic       tx_rd;
  logic [7:0] tx_rdata;
  logic       tx_ack;
  logic       tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_last;
  logic       rx_err;
  logic [2:0] Address;
  logic       WriteEnable;
  logic       ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Rx_Ready;
  logic       Tx_Done;

  modport master (
    input  tx_req, tx_len, tx_rdata, rx_ready, DataOut, Rx_Ready, Tx_Done,
    output tx_rd, tx_ack, tx_err, rx_data, rx_valid, rx_last, rx_err,
           Address, WriteEnable, ReadEnable, DataIn
  );

  modport slave (
    output tx_req, tx_len, tx_rdata, rx_ready, DataOut, Rx_Ready, Tx_Done,
    input  tx_rd, tx_ack, tx_err, rx_data, rx_valid, rx_last, rx_err,
           Address, WriteEnable, ReadEnable, DataIn
  );
endinterface
`default_nettype wire

// File: rtl/hdlc_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_host_ctrl
// Brief    : Round-robin bus master sequencing Hdlc TX loads and RX drains.
//            Optional TX watchdog enabled by HDLC_CTRL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module hdlc_host_ctrl #(
  parameter int TX_MAX = 126,
  parameter int RX_MAX = 126
`ifdef HDLC_CTRL_TIMEOUT_EN
  ,
  parameter int TOUT_CYC = 4096
`endif
) (
  input wire Clk,
  input wire Rst,
  hdlc_host_ctrl_if.master bus
);

  localparam logic [3:0] c_st_idle     = 4'd0;
  localparam logic [3:0] c_st_tx_check = 4'd1;
  localparam logic [3:0] c_st_tx_load  = 4'd2;
  localparam logic [3:0] c_st_tx_wr    = 4'd3;
  localparam logic [3:0] c_st_tx_start = 4'd4;
  localparam logic [3:0] c_st_tx_wait  = 4'd5;
  localparam logic [3:0] c_st_tx_abort = 4'd6;
  localparam logic [3:0] c_st_tx_end   = 4'd7;
  localparam logic [3:0] c_st_rx_len   = 4'd8;
  localparam logic [3:0] c_st_rx_lenw  = 4'd9;
  localparam logic [3:0] c_st_rx_lenc  = 4'd10;
  localparam logic [3:0] c_st_rx_read  = 4'd11;
  localparam logic [3:0] c_st_rx_rdw   = 4'd12;
  localparam logic [3:0] c_st_rx_cap   = 4'd13;
  localparam logic [3:0] c_st_rx_hold  = 4'd14;
  localparam logic [3:0] c_st_rx_end   = 4'd15;

  localparam logic [2:0] c_a_tx_sc   = 3'd0;
  localparam logic [2:0] c_a_tx_buff = 3'd1;
  localparam logic [2:0] c_a_rx_sc   = 3'd2;
  localparam logic [2:0] c_a_rx_buff = 3'd3;
  localparam logic [2:0] c_a_rx_len  = 3'd4;

  localparam logic [7:0] c_tx_max = 8'(TX_MAX);
  localparam logic [7:0] c_rx_max = 8'(RX_MAX);
`ifdef HDLC_CTRL_TIMEOUT_EN
  localparam logic [15:0] c_tout = 16'(TOUT_CYC);
`endif

  logic [3:0] r_state;
  logic       r_rr_rx;   // 1: RX wins the next collision
  logic [7:0] r_cnt;
  logic [1:0] r_hold;
  logic [1:0] r_ign;
  logic       r_tx_rd;
  logic       r_tx_ack;
  logic       r_tx_err;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_last;
  logic       r_rx_err;
  logic [2:0] r_addr;
  logic       r_we;
  logic       r_re;
  logic [7:0] r_data_in;
`ifdef HDLC_CTRL_TIMEOUT_EN
  logic [15:0] r_tout;
`endif

  logic w_rx_cand;
  logic w_tx_cand;
  logic w_grant_rx;
  logic w_tx_bad;
  logic w_rx_bad;

  // Rx_Ready is masked briefly after a frame so the stale level is not re-served
  assign w_rx_cand  = bus.Rx_Ready && (r_hold == 2'd0);
  assign w_tx_cand  = bus.tx_req;
  assign w_grant_rx = w_rx_cand && (!w_tx_cand || r_rr_rx);
  assign w_tx_bad   = (bus.tx_len == 8'd0) || (bus.tx_len > c_tx_max);
  assign w_rx_bad   = (bus.DataOut == 8'd0) || (bus.DataOut > c_rx_max);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= c_st_idle;
      r_rr_rx    <= 1'b1;
      r_cnt      <= 8'd0;
      r_hold     <= 2'd0;
      r_ign      <= 2'd0;
      r_tx_rd    <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_tx_err   <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
      r_rx_err   <= 1'b0;
      r_addr     <= 3'd0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_data_in  <= 8'd0;
`ifdef HDLC_CTRL_TIMEOUT_EN
      r_tout     <= 16'd0;
`endif
    end else begin
      if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
      case (r_state)
        c_st_idle: begin
          if (w_rx_cand || w_tx_cand) begin
            if (w_rx_cand && w_tx_cand) r_rr_rx <= ~r_rr_rx;
            r_state <= w_grant_rx ? c_st_rx_len : c_st_tx_check;
          end
        end
        c_st_tx_check: begin
          if (w_tx_bad) begin
            r_tx_ack <= 1'b1;
            r_tx_err <= 1'b1;
            r_state  <= c_st_tx_end;
          end else begin
            r_cnt   <= bus.tx_len;
            r_state <= c_st_tx_load;
          end
        end
        c_st_tx_load: begin
          r_we <= 1'b0;
          if (r_cnt != 8'd0) begin
            r_tx_rd <= 1'b1;
            r_state <= c_st_tx_wr;
          end else begin
            r_state <= c_st_tx_start;
          end
        end
        c_st_tx_wr: begin
          // tx_rdata is the head byte popped by the tx_rd strobe now on the pin
          r_tx_rd   <= 1'b0;
          r_we      <= 1'b1;
          r_addr    <= c_a_tx_buff;
          r_data_in <= bus.tx_rdata;
          r_cnt     <= r_cnt - 8'd1;
          r_state   <= c_st_tx_load;
        end
        c_st_tx_start: begin
          r_we      <= 1'b1;
          r_addr    <= c_a_tx_sc;
          r_data_in <= 8'h02;
          r_ign     <= 2'd3;
`ifdef HDLC_CTRL_TIMEOUT_EN
          r_tout    <= 16'd0;
`endif
          r_state   <= c_st_tx_wait;
        end
        c_st_tx_wait: begin
          r_we <= 1'b0;
          if (r_ign != 2'd0) begin
            r_ign <= r_ign - 2'd1;
          end else if (bus.Tx_Done) begin
            r_tx_ack <= 1'b1;
            r_state  <= c_st_tx_end;
          end
`ifdef HDLC_CTRL_TIMEOUT_EN
          else if (r_tout == c_tout) begin
            r_we      <= 1'b1;
            r_addr    <= c_a_tx_sc;
            r_data_in <= 8'h04;
            r_state   <= c_st_tx_abort;
          end
          r_tout <= r_tout + 16'd1;
`endif
        end
        c_st_tx_abort: begin
          r_we     <= 1'b0;
          r_tx_ack <= 1'b1;
          r_tx_err <= 1'b1;
          r_state  <= c_st_tx_end;
        end
        c_st_tx_end: begin
          r_tx_ack <= 1'b0;
          r_tx_err <= 1'b0;
          r_state  <= c_st_idle;
        end
        c_st_rx_len: begin
          r_re    <= 1'b1;
          r_addr  <= c_a_rx_len;
          r_state <= c_st_rx_lenw;
        end
        c_st_rx_lenw: begin
          r_re    <= 1'b0;
          r_state <= c_st_rx_lenc;
        end
        c_st_rx_lenc: begin
          if (w_rx_bad) begin
            r_we      <= 1'b1;
            r_addr    <= c_a_rx_sc;
            r_data_in <= 8'h02;
            r_rx_err  <= 1'b1;
            r_state   <= c_st_rx_end;
          end else begin
            r_cnt   <= bus.DataOut;
            r_state <= c_st_rx_read;
          end
        end
        c_st_rx_read: begin
          r_re    <= 1'b1;
          r_addr  <= c_a_rx_buff;
          r_state <= c_st_rx_rdw;
        end
        c_st_rx_rdw: begin
          r_re    <= 1'b0;
          r_state <= c_st_rx_cap;
        end
        c_st_rx_cap: begin
          r_rx_data  <= bus.DataOut;
          r_rx_valid <= 1'b1;
          r_rx_last  <= (r_cnt == 8'd1);
          r_state    <= c_st_rx_hold;
        end
        c_st_rx_hold: begin
          if (bus.rx_ready) begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            if (r_cnt == 8'd1) begin
              r_hold  <= 2'd2;
              r_state <= c_st_idle;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= c_st_rx_read;
            end
          end
        end
        c_st_rx_end: begin
          r_we     <= 1'b0;
          r_rx_err <= 1'b0;
          r_hold   <= 2'd2;
          r_state  <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.tx_rd       = r_tx_rd;
  assign bus.tx_ack      = r_tx_ack;
  assign bus.tx_err      = r_tx_err;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_last     = r_rx_last;
  assign bus.rx_err      = r_rx_err;
  assign bus.Address     = r_addr;
  assign bus.WriteEnable = r_we;
  assign bus.ReadEnable  = r_re;
  assign bus.DataIn      = r_data_in;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_host_ctrl
// Brief    : Directed bench with a behavioural Hdlc register/pin model.
// Revision : 1.0
// ============================================================================
module tb_hdlc_host_ctrl;
  logic Clk = 1'b0;
  logic Rst;

  hdlc_host_ctrl_if bus();

`ifdef HDLC_CTRL_TIMEOUT_EN
  hdlc_host_ctrl #(.TOUT_CYC(100)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`else
  hdlc_host_ctrl dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`endif

  initial forever #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  src     [16];
  logic [7:0]  rx_mem  [8];
  logic [11:0] op_log  [64];
  logic [7:0]  got_data[8];
  logic        got_last[8];
  logic [7:0]  rx_len_v;
  logic        pop_pend, ack_done;
  int src_ptr, n_txrd, n_ack, n_err, n_rxerr, n_both, n_op, n_stall;
  int n_rd3, n_rd4, rx_got, rx_rptr, stall_idx, stall_left, txd_delay, txd_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'd0, bus.tx_rd, bus.tx_ack, bus.tx_err, bus.rx_data, bus.rx_valid,
            bus.rx_last, bus.rx_err, bus.Address, bus.WriteEnable, bus.ReadEnable, bus.DataIn};
  endfunction

  task automatic clear_log();
    src_ptr = 0; pop_pend = 1'b0; bus.tx_rdata = src[0];
    n_txrd = 0; n_ack = 0; n_err = 0; n_rxerr = 0; n_op = 0; n_stall = 0;
    n_rd3 = 0; n_rd4 = 0; rx_got = 0; rx_rptr = 0; ack_done = 1'b0;
  endtask

  // Hdlc core, TX source and RX sink, evaluated mid-cycle
  task automatic model();
    if (pop_pend) src_ptr++;
    pop_pend = bus.tx_rd;
    if (bus.tx_rd) n_txrd++;
    if (src_ptr < 16) bus.tx_rdata = src[src_ptr];
    if (bus.WriteEnable && bus.ReadEnable) n_both++;
    if (bus.WriteEnable) begin
      if (n_op < 64) op_log[n_op] = {1'b1, bus.Address, bus.DataIn};
      n_op++;
      if (bus.Address == 3'd2 && bus.DataIn == 8'h02) bus.Rx_Ready = 1'b0;
    end
    if (bus.WriteEnable && bus.Address == 3'd0 && bus.DataIn == 8'h02) begin
      bus.Tx_Done = 1'b0;
      txd_left = txd_delay;
    end else if (txd_left > 0) begin
      txd_left--;
      if (txd_left == 0) bus.Tx_Done = 1'b1;
    end
    if (bus.ReadEnable) begin
      if (n_op < 64) op_log[n_op] = {1'b0, bus.Address, 8'h00};
      n_op++;
      if (bus.Address == 3'd4) begin
        n_rd4++;
        bus.DataOut = rx_len_v;
      end else if (bus.Address == 3'd3) begin
        n_rd3++;
        if (rx_rptr < 8) bus.DataOut = rx_mem[rx_rptr];
        rx_rptr++;
        if (rx_rptr == int'(rx_len_v)) bus.Rx_Ready = 1'b0;
      end
    end
    if (bus.tx_ack) begin
      n_ack++;
      ack_done = bus.Tx_Done;
      bus.tx_req = 1'b0;
    end
    if (bus.tx_err) n_err++;
    if (bus.rx_err) n_rxerr++;
    if (bus.rx_valid) begin
      if (rx_got == stall_idx && stall_left > 0) begin
        bus.rx_ready = 1'b0;
        stall_left--;
        n_stall++;
      end else begin
        bus.rx_ready = 1'b1;
      end
      if (bus.rx_ready && rx_got < 8) begin
        got_data[rx_got] = bus.rx_data;
        got_last[rx_got] = bus.rx_last;
        rx_got++;
      end
    end else begin
      bus.rx_ready = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    model();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    bus.tx_req = 1'b0; bus.tx_len = 8'd0; bus.tx_rdata = 8'd0; bus.rx_ready = 1'b1;
    bus.DataOut = 8'd0; bus.Rx_Ready = 1'b0; bus.Tx_Done = 1'b0;
    for (int i = 0; i < 16; i++) src[i] = 8'h00;
    for (int i = 0; i < 8; i++) rx_mem[i] = 8'h00;
    rx_len_v = 8'd0; stall_idx = -1; stall_left = 0; txd_delay = -1; txd_left = -1;
    n_both = 0;
    clear_log();

    repeat (3) tick();
    chk("reset_outs", outs(), 32'd0);
    Rst = 1'b1;
    tick(); tick();
    chk("idle_outs", outs(), 32'd0);

    // reset in the middle of a 10-byte load
    for (int i = 0; i < 10; i++) src[i] = 8'h10 + 8'(i);
    clear_log();
    bus.tx_len = 8'd10; bus.tx_req = 1'b1;
    for (int i = 0; i < 60 && n_txrd < 3; i++) tick();
    chk("t1_pops", n_txrd, 3);
    chk("t1_writes", n_op, 2);
    chk("t1_we_before", 32'(bus.WriteEnable), 32'd1);
    Rst = 1'b0;
    #1;
    chk("t1_reset_outs", outs(), 32'd0);
    bus.tx_req = 1'b0;
    tick(); tick();
    Rst = 1'b1;
    repeat (30) tick();
    chk("t1_no_ack", n_ack, 0);
    chk("t1_no_bus", n_op, 2);

    // nominal 3-byte TX
    src[0] = 8'hAA; src[1] = 8'h55; src[2] = 8'h7E;
    clear_log();
    txd_delay = 40; bus.tx_len = 8'd3; bus.tx_req = 1'b1;
    for (int i = 0; i < 300 && n_ack < 1; i++) tick();
    chk("t2_ack", n_ack, 1);
    chk("t2_w0", 32'(op_log[0]), 32'h9AA);
    chk("t2_w1", 32'(op_log[1]), 32'h955);
    chk("t2_w2", 32'(op_log[2]), 32'h97E);
    chk("t2_start", 32'(op_log[3]), 32'h802);
    chk("t2_nops", n_op, 4);
    chk("t2_pops", n_txrd, 3);
    chk("t2_ack_after_done", 32'(ack_done), 32'd1);
    repeat (10) tick();
    chk("t2_single_ack", n_ack, 1);
    chk("t2_no_err", n_err, 0);

    // rejects: zero length and one past TX_MAX
    clear_log();
    bus.tx_len = 8'd0; bus.tx_req = 1'b1;
    for (int i = 0; i < 50 && n_ack < 1; i++) tick();
    repeat (3) tick();
    chk("t3a_ack", n_ack, 1);
    chk("t3a_err", n_err, 1);
    chk("t3a_nops", n_op, 0);
    chk("t3a_pops", n_txrd, 0);
    clear_log();
    bus.tx_len = 8'd127; bus.tx_req = 1'b1;
    for (int i = 0; i < 50 && n_ack < 1; i++) tick();
    repeat (3) tick();
    chk("t3b_ack", n_ack, 1);
    chk("t3b_err", n_err, 1);
    chk("t3b_nops", n_op, 0);
    chk("t3b_pops", n_txrd, 0);

    // RX drain of 4 bytes, second byte stalled 5 cycles
    for (int i = 0; i < 4; i++) rx_mem[i] = 8'(i + 1);
    clear_log();
    rx_len_v = 8'd4; stall_idx = 1; stall_left = 5; bus.Rx_Ready = 1'b1;
    for (int i = 0; i < 300 && rx_got < 4; i++) tick();
    repeat (5) tick();
    chk("t4_got", rx_got, 4);
    chk("t4_bytes", {got_data[0], got_data[1], got_data[2], got_data[3]}, 32'h01020304);
    chk("t4_last", 32'({got_last[0], got_last[1], got_last[2], got_last[3]}), 32'b0001);
    chk("t4_rd3", n_rd3, 4);
    chk("t4_rd4", n_rd4, 1);
    chk("t4_nops", n_op, 5);
    chk("t4_stall", n_stall, 5);
    chk("t4_no_rxerr", n_rxerr, 0);

    // RX zero length is dropped
    clear_log();
    rx_len_v = 8'd0; stall_idx = -1; bus.Rx_Ready = 1'b1;
    for (int i = 0; i < 100 && n_rxerr < 1; i++) tick();
    repeat (5) tick();
    chk("t4d_rxerr", n_rxerr, 1);
    chk("t4d_len_rd", 32'(op_log[0]), 32'h400);
    chk("t4d_drop_wr", 32'(op_log[1]), 32'hA02);
    chk("t4d_nops", n_op, 2);
    chk("t4d_no_data", rx_got, 0);

    // arbitration: two collisions
    rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; src[0] = 8'h33;
    rx_len_v = 8'd2; bus.tx_len = 8'd1; txd_delay = 5;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      bus.tx_req = 1'b1; bus.Rx_Ready = 1'b1;
      for (int i = 0; i < 400 && (n_ack < 1 || rx_got < 2); i++) tick();
      repeat (5) tick();
      chk("t5_nops", n_op, 5);
      chk("t5_ack", n_ack, 1);
      chk("t5_rx_bytes", 32'({got_data[0], got_data[1]}), 32'h1122);
      if (k == 0) begin
        chk("t5a_rx_first", 32'(op_log[0]), 32'h400);
        chk("t5a_tx_second", 32'(op_log[3]), 32'h933);
      end else begin
        chk("t5b_tx_first", 32'(op_log[0]), 32'h933);
        chk("t5b_rx_second", 32'(op_log[2]), 32'h400);
      end
    end

`ifdef HDLC_CTRL_TIMEOUT_EN
    // watchdog abort with Tx_Done stuck low
    src[0] = 8'h5A;
    clear_log();
    txd_delay = -1; bus.Tx_Done = 1'b0; bus.tx_len = 8'd1; bus.tx_req = 1'b1;
    for (int i = 0; i < 400 && n_ack < 1; i++) tick();
    repeat (3) tick();
    chk("t6_ack", n_ack, 1);
    chk("t6_err", n_err, 1);
    chk("t6_abort_wr", 32'(op_log[2]), 32'h804);
    chk("t6_nops", n_op, 3);
`endif

    chk("strobe_exclusive", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
